// File: rtl/sdhci_reg_arbiter_if.sv
// sdhci_reg_arbiter_if
//   Bundles the two requester ports and the SDHCI register-port (BRAM) side
//   of sdhci_reg_arbiter into one interface.
//
//   Requester side (index n = requester n; 0 = CPU bridge, 1 = boot sequencer)
//     req_i[1:0]        access request
//     lock_i[1:0]       keep ownership after this access
//     we_i[1:0]         write enable
//     wmask_i[1:0][3:0] byte write mask
//     addr_i[1:0][5:0]  word address
//     wdata_i[1:0][31:0] write data
//     gnt_o[1:0]        access accepted this cycle (one-hot or zero)
//     rvalid_o[1:0]     read data valid for requester n
//     rdata_o[31:0]     shared read data
//   Register-port side
//     bram_en_o, bram_we_o, bram_wmask_o[3:0], bram_addr_o[5:0],
//     bram_wdata_o[31:0]  strobe and access fields towards the register file
//     bram_rdata_i[31:0]  read data, valid the cycle after a read strobe
//
//   slave modport  : the arbiter's view
//   master modport : the environment's view (requesters plus register file)

interface sdhci_reg_arbiter_if;
    logic [1:0]        req_i;
    logic [1:0]        lock_i;
    logic [1:0]        we_i;
    logic [1:0][3:0]   wmask_i;
    logic [1:0][5:0]   addr_i;
    logic [1:0][31:0]  wdata_i;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [31:0]       rdata_o;
    logic              bram_en_o;
    logic              bram_we_o;
    logic [3:0]        bram_wmask_o;
    logic [5:0]        bram_addr_o;
    logic [31:0]       bram_wdata_o;
    logic [31:0]       bram_rdata_i;

    modport slave (
        input  req_i, lock_i, we_i, wmask_i, addr_i, wdata_i, bram_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
               bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o
    );

    modport master (
        output req_i, lock_i, we_i, wmask_i, addr_i, wdata_i, bram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
               bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o
    );
endinterface

// File: rtl/sdhci_reg_arbiter.sv
// sdhci_reg_arbiter
//   Two-requester arbiter for the 32-bit, 64-word SDHCI register port
//   (1-cycle read latency). Serialises accesses with a combinational
//   (0-cycle) grant, returns read data to the issuing requester one cycle
//   after grant, and supports a bounded lock for read-modify-write sequences.
//
//   Ports
//     clk_i   clock
//     rst_i   asynchronous, active-high reset
//     bus     sdhci_reg_arbiter_if.slave (requester and register-port signals)
//   Parameter
//     MaxLock consecutive grants/cycles a lock owner may hold before forced
//             release, 1..255
//   Build option
//     SDHCI_ARB_RR_EN  defined: round-robin arbitration in IDLE
//                      undefined: fixed priority, requester 0 wins in IDLE
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no owner; winner chosen among asserted requests
//   ST_LOCKED | own_q holds the port; lcnt_q counts grants/cycles held

module sdhci_reg_arbiter #(
    parameter int unsigned MaxLock = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sdhci_reg_arbiter_if.slave   bus
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_MAX = 8'(MaxLock);

    state_t     state_q, state_d;
    logic       own_q, own_d;
    logic [7:0] lcnt_q, lcnt_d;
    logic       last_q, last_d;
    logic       tag_valid_q, tag_valid_d;
    logic       tag_id_q, tag_id_d;

    logic       gnt_any;
    logic       win;
    logic [7:0] lcnt_inc;

    assign lcnt_inc = lcnt_q + 8'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            own_q       <= 1'b0;
            lcnt_q      <= 8'd0;
            last_q      <= 1'b1;
            tag_valid_q <= 1'b0;
            tag_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            lcnt_q      <= lcnt_d;
            last_q      <= last_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
        end
    end

    always_comb begin
        gnt_any     = 1'b0;
        win         = 1'b0;
        state_d     = state_q;
        own_d       = own_q;
        lcnt_d      = lcnt_q;
        last_d      = last_q;
        tag_valid_d = 1'b0;
        tag_id_d    = tag_id_q;

        // winner selection
        case (state_q)
            ST_IDLE: begin
`ifdef SDHCI_ARB_RR_EN
                if (bus.req_i == 2'b11) begin
                    gnt_any = 1'b1;
                    win     = ~last_q;
                end else if (bus.req_i[0]) begin
                    gnt_any = 1'b1;
                    win     = 1'b0;
                end else if (bus.req_i[1]) begin
                    gnt_any = 1'b1;
                    win     = 1'b1;
                end
`else
                if (bus.req_i[0]) begin
                    gnt_any = 1'b1;
                    win     = 1'b0;
                end else if (bus.req_i[1]) begin
                    gnt_any = 1'b1;
                    win     = 1'b1;
                end
`endif
            end
            ST_LOCKED: begin
                win     = own_q;
                gnt_any = bus.req_i[own_q];
            end
            default: ;
        endcase

        // lock bookkeeping
        case (state_q)
            ST_IDLE: begin
                lcnt_d = 8'd0;
                // a bound of 1 means the entering grant already exhausts the lock
                if (gnt_any && bus.lock_i[win] && (LOCK_MAX != 8'd1)) begin
                    state_d = ST_LOCKED;
                    own_d   = win;
                    lcnt_d  = 8'd1;
                end
            end
            ST_LOCKED: begin
                // an idle owner cycle counts too, so an abandoned lock expires
                if ((gnt_any && !bus.lock_i[own_q]) || (lcnt_inc == LOCK_MAX)) begin
                    state_d = ST_IDLE;
                    lcnt_d  = 8'd0;
                end else begin
                    lcnt_d  = lcnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lcnt_d  = 8'd0;
            end
        endcase

        if (gnt_any) begin
            last_d      = win;
            tag_valid_d = ~bus.we_i[win];
            tag_id_d    = win;
        end
    end

    assign bus.gnt_o        = gnt_any ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign bus.bram_en_o    = gnt_any;
    assign bus.bram_we_o    = gnt_any & bus.we_i[win];
    assign bus.bram_wmask_o = gnt_any ? bus.wmask_i[win] : 4'h0;
    // with no grant the don't-care fields follow requester 0
    assign bus.bram_addr_o  = gnt_any ? bus.addr_i[win]  : bus.addr_i[0];
    assign bus.bram_wdata_o = gnt_any ? bus.wdata_i[win] : bus.wdata_i[0];

    assign bus.rvalid_o     = tag_valid_q ? (tag_id_q ? 2'b10 : 2'b01) : 2'b00;
    // held at zero outside a read return so the port is quiet after reset
    assign bus.rdata_o      = tag_valid_q ? bus.bram_rdata_i : 32'h0;

endmodule

// File: tb/tb_sdhci_reg_arbiter.sv
// tb_sdhci_reg_arbiter
//   Directed bench for sdhci_reg_arbiter with MaxLock = 4 and a 64-word
//   byte-maskable register-file model with 1-cycle read latency.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   on the falling edge.

module tb_sdhci_reg_arbiter;

    localparam int unsigned MAX_LOCK = 4;
`ifdef SDHCI_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    sdhci_reg_arbiter_if bus ();

    sdhci_reg_arbiter #(.MaxLock(MAX_LOCK)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    bit   [31:0] mem [64];
    logic [31:0] bram_q = 32'h0;
    assign bus.bram_rdata_i = bram_q;

    always @(posedge clk_i) begin
        if (bus.bram_en_o) begin
            if (bus.bram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.bram_wmask_o[b])
                        mem[bus.bram_addr_o][8*b +: 8] <= bus.bram_wdata_o[8*b +: 8];
            end else begin
                bram_q <= mem[bus.bram_addr_o];
            end
        end
    end

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic drive(input int n, input bit r, input bit lk, input bit w,
                         input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.req_i[n]   = r;
        bus.lock_i[n]  = lk;
        bus.we_i[n]    = w;
        bus.addr_i[n]  = a;
        bus.wdata_i[n] = d;
        bus.wmask_i[n] = m;
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {22'h0, bus.gnt_o, bus.rvalid_o, bus.bram_en_o, bus.bram_we_o, bus.bram_wmask_o};
    endfunction

    logic [1:0] exp_g;
    logic [1:0] prev_g;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_i = 1'b1;
        idle_all();

        // reset state
        @(negedge clk_i);
        chk("rst_outs", all_outs(), 32'h0);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_outs", all_outs(), 32'h0);

        // write 0x0C then read it back immediately
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b1, 6'h0C, 32'hDEADBEEF, 4'hF);
        @(negedge clk_i);
        chk("wr_gnt", bus.gnt_o, 2'b01);
        chk("wr_we", bus.bram_we_o, 1'b1);
        chk("wr_mask", bus.bram_wmask_o, 4'hF);
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 6'h0C, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("wr_no_rvalid", bus.rvalid_o, 2'b00);
        chk("rd_gnt", bus.gnt_o, 2'b01);
        chk("rd_en", bus.bram_en_o, 1'b1);
        chk("rd_addr", bus.bram_addr_o, 6'h0C);
        chk("rd_we", bus.bram_we_o, 1'b0);
        next_cycle();
        idle_all();
        @(negedge clk_i);
        chk("rd_rvalid", bus.rvalid_o, 2'b01);
        chk("rd_data", bus.rdata_o, 32'hDEADBEEF);
        chk("idle_gnt", bus.gnt_o, 2'b00);
        chk("idle_outs", {bus.bram_en_o, bus.bram_we_o, bus.bram_wmask_o}, 6'h0);

        // partial-mask write then read: bytes 0 and 2 replaced
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b1, 6'h0C, 32'hAABBCCDD, 4'b0101);
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 6'h0C, 32'h0, 4'h0);
        next_cycle();
        idle_all();
        @(negedge clk_i);
        chk("mask_rdata", bus.rdata_o, 32'hDEBBBEDD);

        // contention from a fresh reset
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        prev_g = 2'b00;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if (k < 4) begin
                drive(0, 1'b1, 1'b0, 1'b0, 6'h01, 32'h0, 4'h0);
                drive(1, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0, 4'h0);
            end else begin
                idle_all();
            end
            @(negedge clk_i);
            if (k < 4) begin
                exp_g = (RR_EN && (k % 2 == 1)) ? 2'b10 : 2'b01;
                chk($sformatf("cont_gnt%0d", k), bus.gnt_o, exp_g);
            end else begin
                exp_g = 2'b00;
            end
            if (k > 0) chk($sformatf("cont_rvalid%0d", k), bus.rvalid_o, prev_g);
            prev_g = exp_g;
        end

        // lock RMW by requester 1 while requester 0 waits
        next_cycle();
        drive(1, 1'b1, 1'b1, 1'b0, 6'h0C, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("rmw_rd_gnt", bus.gnt_o, 2'b10);
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 6'h0C, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 1'b1, 6'h0C, 32'hCAFEF00D, 4'hF);
        @(negedge clk_i);
        chk("rmw_wr_gnt", bus.gnt_o, 2'b10);
        chk("rmw_rvalid", bus.rvalid_o, 2'b10);
        chk("rmw_rdata", bus.rdata_o, 32'hDEBBBEDD);
        next_cycle();
        drive(1, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("rmw_r0_gnt", bus.gnt_o, 2'b01);
        next_cycle();
        idle_all();
        @(negedge clk_i);
        chk("rmw_r0_rvalid", bus.rvalid_o, 2'b01);
        chk("rmw_r0_rdata", bus.rdata_o, 32'hCAFEF00D);

        // forced release after MAX_LOCK locked grants to requester 1
        next_cycle();
        drive(1, 1'b1, 1'b1, 1'b0, 6'h03, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("frc_gnt0", bus.gnt_o, 2'b10);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive(0, 1'b1, 1'b0, 1'b0, 6'h04, 32'h0, 4'h0);
            @(negedge clk_i);
            chk($sformatf("frc_gnt%0d", k), bus.gnt_o, (k < 4) ? 2'b10 : 2'b01);
        end
        next_cycle();
        idle_all();
        @(negedge clk_i);
        chk("frc_idle", bus.gnt_o, 2'b00);

        // abandoned lock by requester 0
        next_cycle();
        drive(0, 1'b1, 1'b1, 1'b0, 6'h05, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("abn_take", bus.gnt_o, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive(0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
            drive(1, 1'b1, 1'b0, 1'b0, 6'h06, 32'h0, 4'h0);
            @(negedge clk_i);
            chk($sformatf("abn_gnt%0d", k), bus.gnt_o, (k < 4) ? 2'b00 : 2'b10);
        end
        next_cycle();
        idle_all();

        // reset asserted in the grant cycle of a read
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 6'h0C, 32'h0, 4'h0);
        #3;
        rst_i = 1'b1;
        next_cycle();
        idle_all();
        @(negedge clk_i);
        chk("rstrd_outs", all_outs(), 32'h0);
        chk("rstrd_rdata", bus.rdata_o, 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rstrd_post_outs", all_outs(), 32'h0);
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 6'h0C, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("rstrd_gnt", bus.gnt_o, 2'b01);
        next_cycle();
        idle_all();
        @(negedge clk_i);
        chk("rstrd_rvalid", bus.rvalid_o, 2'b01);
        chk("rstrd_rdata2", bus.rdata_o, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
